// File: rtl/img_pkg.sv
// img_pkg: shared state encoding and trailer layout for the frame packer.
// Imported by img_frame_packer and available to other packer paths.
package img_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        INFO,
        PAD,
        DONE
    } state_t;

    localparam int INFO_WORDS   = 3;
    localparam int DW0_ERR_BIT  = 31;
    localparam int DW0_SEQ_LSB  = 16;
    localparam int DW0_TYPE_LSB = 8;

    function automatic logic [31:0] pack_dw0(
        input logic       err,
        input logic [7:0] seq,
        input logic [1:0] typ
    );
        logic [31:0] w;
        w = '0;
        w[DW0_ERR_BIT] = err;
        w[DW0_SEQ_LSB +: 8] = seq;
        w[DW0_TYPE_LSB +: 2] = typ;
        return w;
    endfunction

endpackage

// File: rtl/img_parity_acc.sv
// img_parity_acc: W-bit running XOR with synchronous clear and enable.
// clr takes priority over en.
module img_parity_acc #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] acc
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc ^ din;
        end
    end

endmodule

// File: rtl/img_frame_packer.sv
// img_frame_packer: frames FRAME_WORDS stream words and appends a
// parity/info/zero trailer toward the DDR write FIFO.
module img_frame_packer
    import img_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int FRAME_WORDS = 262144,
    parameter int PAD_WORDS   = 256,
    parameter int CNT_W       = $clog2(FRAME_WORDS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              frame_start,
    input  logic [1:0]        frame_type_i,
    input  logic              wr_en,
    input  logic [3:0]        type_mask,
    input  logic              ovf_clr,
    output logic [DATA_W-1:0] fifo_wrdata,
    output logic              fifo_wren,
    input  logic              fifo_full,
    output logic              frame_done,
    output logic [1:0]        frame_type_o,
    output logic              frame_err,
    output logic [7:0]        frame_seq,
    output logic              overflow_sticky
);

    localparam int TRL_W = $clog2(PAD_WORDS + 1);
    localparam int ZPAD  = PAD_WORDS - 1 - INFO_WORDS;

    logic [DATA_W-1:0] s_data_q;
    logic              s_valid_q;
    logic              start_q;
    logic              start_qq;
    logic [1:0]        type_q;
    logic              wr_en_q;
    logic [3:0]        mask_q;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  drop_cnt;
    logic [TRL_W-1:0]  trl_cnt;
    logic              store_en;
    logic              err;
    logic [DATA_W-1:0] acc;
    logic [31:0]       info_w;
    logic [DATA_W-1:0] wrdata_nxt;
    logic              wren_nxt;
    logic              store;
    logic              start_rise;
    logic              last_data;
    logic              drop;
    logic              arm;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_data_q  <= '0;
            s_valid_q <= 1'b0;
            start_q   <= 1'b0;
            start_qq  <= 1'b0;
            type_q    <= '0;
            wr_en_q   <= 1'b0;
            mask_q    <= '0;
        end else begin
            s_data_q  <= s_data;
            s_valid_q <= s_valid;
            start_q   <= frame_start;
            start_qq  <= start_q;
            type_q    <= frame_type_i;
            wr_en_q   <= wr_en;
            mask_q    <= type_mask;
        end
    end

    assign start_rise = start_q & ~start_qq;
    assign arm        = (state == IDLE) & start_rise;
    assign last_data  = (cnt == CNT_W'(FRAME_WORDS - 1));
    assign drop       = (state == DATA) & s_valid_q & fifo_full;
    // wr_en_q gates writes in the same cycle it drops
    assign store      = store_en & wr_en_q;

    img_parity_acc #(
        .W(DATA_W)
    ) u_parity (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (arm),
        .en   ((state == DATA) & s_valid_q),
        .din  (s_data_q),
        .acc  (acc)
    );

    always_comb begin
        info_w = '0;
        unique case (1'b1)
            trl_cnt == TRL_W'(0): info_w = pack_dw0(err, frame_seq, frame_type_o);
            trl_cnt == TRL_W'(1): info_w = 32'(FRAME_WORDS);
            default:              info_w = 32'(drop_cnt);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        wren_nxt   = 1'b0;
        wrdata_nxt = '0;
        unique case (state)
            IDLE: begin
                if (start_rise) state_nxt = DATA;
            end
            DATA: begin
                wrdata_nxt = s_data_q;
                wren_nxt   = store & s_valid_q & ~fifo_full;
                if (s_valid_q && last_data) state_nxt = PARITY;
            end
            PARITY: begin
                wrdata_nxt = acc;
                wren_nxt   = store & ~fifo_full;
                if (!fifo_full) state_nxt = INFO;
            end
            INFO: begin
                wrdata_nxt = DATA_W'(info_w);
                wren_nxt   = store & ~fifo_full;
                if (!fifo_full && trl_cnt == TRL_W'(INFO_WORDS - 1))
                    state_nxt = (ZPAD == 0) ? DONE : PAD;
            end
            PAD: begin
                wren_nxt = store & ~fifo_full;
                if (!fifo_full && trl_cnt == TRL_W'(ZPAD - 1))
                    state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_wrdata     <= '0;
            fifo_wren       <= 1'b0;
            frame_done      <= 1'b0;
            frame_err       <= 1'b0;
            frame_type_o    <= '0;
            frame_seq       <= '0;
            overflow_sticky <= 1'b0;
            cnt             <= '0;
            drop_cnt        <= '0;
            trl_cnt         <= '0;
            store_en        <= 1'b0;
            err             <= 1'b0;
        end else begin
            fifo_wrdata <= wrdata_nxt;
            fifo_wren   <= wren_nxt;
            frame_done  <= (state == DONE);
            frame_err   <= (state == DONE) & err;
            if (arm) begin
                frame_type_o <= type_q;
                frame_seq    <= frame_seq + 8'd1;
                err          <= 1'b0;
                drop_cnt     <= '0;
                cnt          <= '0;
                store_en     <= wr_en_q & mask_q[type_q];
            end else begin
                if (!wr_en_q) store_en <= 1'b0;
                if (drop) begin
                    err      <= 1'b1;
                    drop_cnt <= drop_cnt + CNT_W'(1);
                end
                if (state == DATA && s_valid_q)
                    cnt <= last_data ? '0 : cnt + CNT_W'(1);
            end
            if ((state == INFO || state == PAD) && !fifo_full)
                trl_cnt <= (state_nxt != state) ? '0 : trl_cnt + TRL_W'(1);
            else if (state != INFO && state != PAD)
                trl_cnt <= '0;
            if (ovf_clr) overflow_sticky <= 1'b0;
            else if (drop) overflow_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_img_frame_packer.sv
// tb_img_frame_packer: directed and random frames against a queue model
// built from the framing rules (data, parity, info, zero pad).
module tb_img_frame_packer;

    localparam int DW  = 32;
    localparam int FW  = 16;
    localparam int PW  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          frame_start = 1'b0;
    logic [1:0]    frame_type_i = '0;
    logic          wr_en = 1'b0;
    logic [3:0]    type_mask = '0;
    logic          ovf_clr = 1'b0;
    logic [DW-1:0] fifo_wrdata;
    logic          fifo_wren;
    logic          fifo_full = 1'b0;
    logic          frame_done;
    logic [1:0]    frame_type_o;
    logic          frame_err;
    logic [7:0]    frame_seq;
    logic          overflow_sticky;

    int n_assert = 0;
    int n_fail = 0;
    int exp_seq = 0;
    bit exp_sticky = 1'b0;
    logic [31:0] wq[$];
    logic [31:0] eq[$];

    img_frame_packer #(
        .DATA_W(DW),
        .FRAME_WORDS(FW),
        .PAD_WORDS(PW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .s_data(s_data),
        .s_valid(s_valid),
        .frame_start(frame_start),
        .frame_type_i(frame_type_i),
        .wr_en(wr_en),
        .type_mask(type_mask),
        .ovf_clr(ovf_clr),
        .fifo_wrdata(fifo_wrdata),
        .fifo_wren(fifo_wren),
        .fifo_full(fifo_full),
        .frame_done(frame_done),
        .frame_type_o(frame_type_o),
        .frame_err(frame_err),
        .frame_seq(frame_seq),
        .overflow_sticky(overflow_sticky)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && fifo_wren) wq.push_back(fifo_wrdata);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_wren"}, 32'(fifo_wren), 0);
        chk({tag, "_done"}, 32'(frame_done), 0);
        chk({tag, "_err"}, 32'(frame_err), 0);
        chk({tag, "_type"}, 32'(frame_type_o), 0);
        chk({tag, "_seq"}, 32'(frame_seq), 0);
        chk({tag, "_ovf"}, 32'(overflow_sticky), 0);
        chk({tag, "_wrdata"}, fifo_wrdata, 0);
    endtask

    task automatic clear_ovf();
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        exp_sticky = 1'b0;
        @(negedge clk);
        chk("ovf_clr", 32'(overflow_sticky), 0);
        step();
    endtask

    task automatic run_frame(
        input logic [1:0]  typ,
        input logic [3:0]  mask,
        input logic [15:0] fullm,
        input int          drop_after,
        input int          restart_k,
        input int          stall_at,
        input int          stall_len,
        input int          rst_at,
        input bit          directed
    );
        logic [31:0] w[FW];
        logic [31:0] par;
        int drops;
        bit st;
        bit got_done;
        int done_i;
        int hits;

        for (int k = 0; k < FW; k++)
            w[k] = directed ? 32'(k + 1) : $urandom;

        st = mask[typ];
        par = '0;
        drops = 0;
        eq.delete();
        for (int k = 0; k < FW; k++) begin
            par ^= w[k];
            if (fullm[k]) drops++;
            else if (st && k < drop_after) eq.push_back(w[k]);
        end
        exp_seq = (exp_seq + 1) % 256;
        if (st && drop_after >= FW) begin
            eq.push_back(par);
            eq.push_back({drops > 0, 7'd0, 8'(exp_seq), 6'd0, typ, 8'd0});
            eq.push_back(32'(FW));
            eq.push_back(32'(drops));
            for (int p = 0; p < PW - 4; p++) eq.push_back(32'd0);
        end
        if (drops > 0) exp_sticky = 1'b1;

        wq.delete();
        frame_type_i = typ;
        type_mask = mask;
        wr_en = 1'b1;
        frame_start = 1'b1;
        step();
        for (int k = 0; k < FW; k++) begin
            if (k == 0) frame_start = 1'b0;
            if (k == restart_k) frame_start = 1'b1;
            if (k == restart_k + 2) frame_start = 1'b0;
            wr_en = (k < drop_after);
            s_data = w[k];
            s_valid = 1'b1;
            fifo_full = (k > 0) ? fullm[k-1] : 1'b0;
            step();
        end
        s_valid = 1'b0;
        s_data = '0;
        fifo_full = fullm[FW-1];
        step();

        got_done = 1'b0;
        done_i = -1;
        for (int i = 0; i < 40; i++) begin
            fifo_full = (i >= stall_at && i < stall_at + stall_len);
            if (i == rst_at) rst_n = 1'b0;
            if (rst_at >= 0 && i == rst_at + 2) begin
                rst_n = 1'b1;
                break;
            end
            @(negedge clk);
            if (frame_done) begin
                got_done = 1'b1;
                done_i = i;
                chk("done_err", 32'(frame_err), 32'(drops > 0));
                chk("done_seq", 32'(frame_seq), 32'(exp_seq));
                chk("done_type", 32'(frame_type_o), 32'(typ));
                chk("done_ovf", 32'(overflow_sticky), 32'(exp_sticky));
                break;
            end
            step();
        end
        fifo_full = 1'b0;
        wr_en = 1'b1;

        if (rst_at >= 0) begin
            chk("rst_no_done", 32'(got_done), 0);
            exp_seq = 0;
            exp_sticky = 1'b0;
            hits = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (frame_done) hits++;
            end
            chk("rst_done_cnt", 32'(hits), 0);
            chk_idle_outputs("rst_mid");
            step();
        end else begin
            chk("done_seen", 32'(got_done), 1);
            chk("done_cyc", 32'(done_i), 32'(PW + 1 + stall_len));
            step();
            chk("frame_nwr", 32'(wq.size()), 32'(eq.size()));
            for (int i = 0; i < eq.size() && i < wq.size(); i++)
                chk($sformatf("wr%0d", i), wq[i], eq[i]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        step();

        // clean frame, data 1..16
        run_frame(2'd0, 4'b0001, 16'h0000, 99, -10, -1, 0, -1, 1'b1);
        // masked type
        run_frame(2'd2, 4'b0001, 16'h0000, 99, -10, -1, 0, -1, 1'b0);
        // overflow on words 5 and 6
        run_frame(2'd1, 4'b0010, 16'h0030, 99, -10, -1, 0, -1, 1'b0);
        // trailer backpressure in PAD; sticky still held
        run_frame(2'd3, 4'b1000, 16'h0000, 99, -10, 5, 3, -1, 1'b0);
        clear_ovf();
        // wr_en drops after word 8, ignored start rise mid-frame
        run_frame(2'd0, 4'b0001, 16'h0000, 8, 4, -1, 0, -1, 1'b0);
        run_frame(2'd0, 4'b1111, 16'h0000, 99, -10, -1, 0, -1, 1'b0);

        for (int r = 0; r < 4; r++) begin
            run_frame(2'($urandom), 4'($urandom),
                      16'($urandom) & 16'($urandom) & 16'($urandom),
                      99, -10, -1, 0, -1, 1'b0);
            @(negedge clk);
            chk("rand_ovf", 32'(overflow_sticky), 32'(exp_sticky));
            step();
            if (exp_sticky) clear_ovf();
        end

        // reset during PAD, then a fresh frame restarts at seq 1
        run_frame(2'd1, 4'b0010, 16'h0000, 99, -10, -1, 0, 5, 1'b0);
        run_frame(2'd1, 4'b0010, 16'h0000, 99, -10, -1, 0, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
